// File: rtl/voice_mix_scheduler_pkg.sv
// Shared types, constants and helpers for the voice mix scheduler.
//   mix_state_t    : scheduler FSM state encoding
//   sat_to_sample(): clamp a wide signed value to a signed range of a given width
package voice_mix_scheduler_pkg;

  localparam int unsigned NUM_VOICES_DEF  = 8;
  localparam int unsigned SAMPLE_W_DEF    = 24;
  localparam int unsigned ACK_TIMEOUT_DEF = 64;

  // Working width for the saturation helper; wide enough for any legal accumulator.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    NEXT,
    WRITE
  } mix_state_t;

  // Clamp value into [-2^(width-1), 2^(width-1)-1]. The caller truncates the
  // result to width bits, which is lossless after clamping.
  function automatic logic signed [SAT_W-1:0] sat_to_sample(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/lrclk_tick_sync.sv
// LRCLK frame-tick generator.
// Brings the asynchronous I2S LRCLK into the clk domain with a 2-flop
// synchroniser and emits a one-cycle tick on its rising edge.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   lrclk : I2S frame clock (asynchronous)
//   tick  : one-cycle pulse per synchronised LRCLK rising edge
module lrclk_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic lrclk,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= lrclk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // sync1_q may be metastable; only sync2_q and later are used.
  assign tick = sync2_q & ~edge_q;

endmodule

// File: rtl/voice_mix_scheduler.sv
// Per-frame voice mixer / scheduler.
// On each LRCLK frame tick, polls every enabled voice in index order over a
// req/ack handshake, accumulates the samples, saturates the sum and writes
// one sample into the audio FIFO. Ticks arriving mid-frame are dropped and
// counted; voices that do not answer in time are treated as silent.
//   CLK, RESET       : clock, asynchronous active-high reset
//   LRCLK            : I2S frame clock (asynchronous)
//   VOICE_EN         : per-voice enable, latched at frame start
//   VOICE_REQ/IDX    : sample request and addressed voice
//   VOICE_ACK/SAMPLE : one-cycle ack with the voice sample
//   FIFO_FULL        : FIFO write-side full flag
//   FIFO_WRITE       : one-cycle write strobe, AUDIO_OUT valid with it
//   BUSY             : frame in progress
//   OVERRUN          : sticky, a tick was dropped
//   DROP_COUNT       : saturating count of dropped ticks
//   TIMEOUT_FLAG     : sticky, a voice missed its ack window
module voice_mix_scheduler
  import voice_mix_scheduler_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = NUM_VOICES_DEF,
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          LRCLK,
  input  logic [NUM_VOICES-1:0]         VOICE_EN,
  output logic                          VOICE_REQ,
  output logic [$clog2(NUM_VOICES)-1:0] VOICE_IDX,
  input  logic                          VOICE_ACK,
  input  logic [SAMPLE_W-1:0]           VOICE_SAMPLE,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_WRITE,
  output logic [SAMPLE_W-1:0]           AUDIO_OUT,
  output logic                          BUSY,
  output logic                          OVERRUN,
  output logic [7:0]                    DROP_COUNT,
  output logic                          TIMEOUT_FLAG
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  // Headroom of IDX_W bits means the sum of all voices can never wrap.
  localparam int unsigned ACC_W = SAMPLE_W + IDX_W;
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(ACK_TIMEOUT - 1);

  mix_state_t                 state_q;
  logic [NUM_VOICES-1:0]      en_q;
  logic [IDX_W-1:0]           idx_q;
  logic [TMR_W-1:0]           timer_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic                       fifo_write_q;
  logic [SAMPLE_W-1:0]        audio_q;
  logic                       overrun_q;
  logic [7:0]                 drop_q;
  logic                       timeout_q;
  logic                       tick;

  lrclk_tick_sync u_tick_sync (
    .clk   (CLK),
    .rst   (RESET),
    .lrclk (LRCLK),
    .tick  (tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      en_q         <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      acc_q        <= '0;
      fifo_write_q <= 1'b0;
      audio_q      <= '0;
      overrun_q    <= 1'b0;
      drop_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      fifo_write_q <= 1'b0;

      // Any tick outside IDLE is dropped, including the cycle WRITE hands
      // back to IDLE.
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
        if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (tick) begin
            en_q    <= VOICE_EN;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end

        SCAN: begin
          if (en_q[idx_q]) begin
            timer_q <= '0;
            state_q <= REQ;
          end else if (idx_q == LAST_IDX) begin
            state_q <= WRITE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        REQ: begin
          // ACK is checked first so it wins over a same-cycle timeout.
          if (VOICE_ACK) begin
            acc_q   <= acc_q + ACC_W'($signed(VOICE_SAMPLE));
            state_q <= NEXT;
          end else if (timer_q == TMR_LIMIT) begin
            timeout_q <= 1'b1;
            state_q   <= NEXT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= WRITE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= SCAN;
          end
        end

        WRITE: begin
          if (!FIFO_FULL) begin
            fifo_write_q <= 1'b1;
            audio_q      <= SAMPLE_W'(sat_to_sample(SAT_W'(acc_q), SAMPLE_W));
            state_q      <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign VOICE_REQ    = (state_q == REQ);
  assign VOICE_IDX    = idx_q;
  assign BUSY         = (state_q != IDLE);
  assign FIFO_WRITE   = fifo_write_q;
  assign AUDIO_OUT    = audio_q;
  assign OVERRUN      = overrun_q;
  assign DROP_COUNT   = drop_q;
  assign TIMEOUT_FLAG = timeout_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Self-checking bench for voice_mix_scheduler: directed table frames, random
// frames against a behavioural mixing model, and hand-written sequences for
// FIFO back-pressure / dropped ticks and asynchronous reset.
module tb_voice_mix_scheduler;

  localparam int NV = 8;
  localparam int SW = 24;
  localparam int TO = 64;
  localparam int IW = 3;

  logic          CLK;
  logic          RESET;
  logic          LRCLK;
  logic [NV-1:0] VOICE_EN;
  logic          VOICE_REQ;
  logic [IW-1:0] VOICE_IDX;
  logic          VOICE_ACK = 1'b0;
  logic [SW-1:0] VOICE_SAMPLE = '0;
  logic          FIFO_FULL;
  logic          FIFO_WRITE;
  logic [SW-1:0] AUDIO_OUT;
  logic          BUSY;
  logic          OVERRUN;
  logic [7:0]    DROP_COUNT;
  logic          TIMEOUT_FLAG;

  voice_mix_scheduler #(
    .NUM_VOICES  (NV),
    .SAMPLE_W    (SW),
    .ACK_TIMEOUT (TO)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .LRCLK        (LRCLK),
    .VOICE_EN     (VOICE_EN),
    .VOICE_REQ    (VOICE_REQ),
    .VOICE_IDX    (VOICE_IDX),
    .VOICE_ACK    (VOICE_ACK),
    .VOICE_SAMPLE (VOICE_SAMPLE),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WRITE   (FIFO_WRITE),
    .AUDIO_OUT    (AUDIO_OUT),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN),
    .DROP_COUNT   (DROP_COUNT),
    .TIMEOUT_FLAG (TIMEOUT_FLAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Voice behaviour: sample value and ack delay (cycles after REQ rises; >= TO never acks).
  logic [SW-1:0] v_smp [NV];
  int            v_dly [NV];
  bit            resp_en   = 1'b1;
  bit            force_ack = 1'b0;

  // Observed traffic.
  int            req_cnt = 0;
  int            cur_idx = 0;
  bit            idx_moved = 1'b0;
  int            req_idx_q [$];
  int            req_len_q [$];
  logic [SW-1:0] wr_q [$];
  int            wr_cnt = 0;

  // Model state.
  logic [SW-1:0] m_out;
  bit            m_to;
  logic [63:0]   m_idx_sig;
  logic [63:0]   m_len_sig;
  bit            to_sticky  = 1'b0;
  bit            ovr_model  = 1'b0;
  int            drop_model = 0;

  typedef struct packed {
    logic [7:0]         en;
    logic [7:0][23:0]   smp;
    logic [7:0][7:0]    dly;
    logic [23:0]        exp_out;
    logic               exp_to;
  } vec_t;

  vec_t vecs [9];

  // Voice responder and bus monitor, evaluated away from the active edge.
  always @(negedge CLK) begin
    if (FIFO_WRITE) begin
      wr_q.push_back(AUDIO_OUT);
      wr_cnt++;
    end
    if (VOICE_REQ) begin
      if (req_cnt == 0) begin
        cur_idx = int'(VOICE_IDX);
        req_idx_q.push_back(cur_idx);
      end else if (int'(VOICE_IDX) != cur_idx) begin
        idx_moved = 1'b1;
      end
      req_cnt++;
    end else if (req_cnt > 0) begin
      req_len_q.push_back(req_cnt);
      req_cnt = 0;
    end
    if (!resp_en) begin
      VOICE_ACK    = force_ack;
      VOICE_SAMPLE = SW'($urandom);
    end else if (VOICE_REQ && (req_cnt > v_dly[cur_idx])) begin
      VOICE_ACK    = 1'b1;
      VOICE_SAMPLE = v_smp[cur_idx];
    end else begin
      VOICE_ACK    = 1'b0;
      VOICE_SAMPLE = SW'($urandom);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Mixing rules stated directly: enabled voices in index order, silent if the
  // ack window is missed, plain integer sum clamped to the sample range.
  function automatic void model_frame(input logic [NV-1:0] en);
    longint sum;
    longint lim;
    int     len;
    sum = 0;
    lim = longint'(1) << (SW - 1);
    m_to = 1'b0;
    m_idx_sig = '0;
    m_len_sig = '0;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) begin
        if (v_dly[i] < TO) begin
          sum += longint'($signed(v_smp[i]));
          len = v_dly[i] + 1;
        end else begin
          m_to = 1'b1;
          len = TO;
        end
        m_idx_sig = (m_idx_sig << 4) | 64'(i + 1);
        m_len_sig = (m_len_sig << 8) | 64'(len);
      end
    end
    if (sum > lim - 1) sum = lim - 1;
    if (sum < -lim) sum = -lim;
    m_out = SW'(sum);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     64'(VOICE_REQ),    64'd0);
    check({tag, "_idx"},     64'(VOICE_IDX),    64'd0);
    check({tag, "_write"},   64'(FIFO_WRITE),   64'd0);
    check({tag, "_audio"},   64'(AUDIO_OUT),    64'd0);
    check({tag, "_busy"},    64'(BUSY),         64'd0);
    check({tag, "_overrun"}, 64'(OVERRUN),      64'd0);
    check({tag, "_drops"},   64'(DROP_COUNT),   64'd0);
    check({tag, "_timeout"}, 64'(TIMEOUT_FLAG), 64'd0);
  endtask

  task automatic wait_write(input int budget, output logic [SW-1:0] val);
    int cyc;
    cyc = 0;
    while ((wr_q.size() == 0) && (cyc < budget)) begin
      step(1);
      cyc++;
    end
    check("write_seen", 64'(wr_q.size() > 0), 64'd1);
    if (wr_q.size() > 0) val = wr_q.pop_front();
    else val = 'x;
  endtask

  // One full frame: tick, wait for the write, compare value, order, hold times and flags.
  task automatic run_frame(input logic [NV-1:0] en, input logic [SW-1:0] exp_out,
                           input logic exp_to, input string tag);
    logic [SW-1:0] got;
    logic [63:0]   a_idx;
    logic [63:0]   a_len;
    int            start;
    model_frame(en);
    req_idx_q.delete();
    req_len_q.delete();
    wr_q.delete();
    idx_moved = 1'b0;
    start = wr_cnt;
    VOICE_EN = en;
    LRCLK = 1'b1;
    wait_write(1500, got);
    check({tag, "_audio"}, 64'(got), 64'(exp_out));
    LRCLK = 1'b0;
    step(6);
    check({tag, "_writes"}, 64'(wr_cnt - start), 64'd1);
    a_idx = '0;
    a_len = '0;
    foreach (req_idx_q[k]) a_idx = (a_idx << 4) | 64'(req_idx_q[k] + 1);
    foreach (req_len_q[k]) a_len = (a_len << 8) | 64'(req_len_q[k]);
    check({tag, "_req_order"}, a_idx, m_idx_sig);
    check({tag, "_req_hold"},  a_len, m_len_sig);
    check({tag, "_idx_stable"}, 64'(idx_moved), 64'd0);
    check({tag, "_timeout"}, 64'(TIMEOUT_FLAG), 64'(exp_to));
    check({tag, "_overrun"}, 64'(OVERRUN), 64'(ovr_model));
    check({tag, "_drops"}, 64'(DROP_COUNT), 64'(drop_model));
    check({tag, "_busy"}, 64'(BUSY), 64'd0);
  endtask

  function automatic vec_t mk(input logic [7:0] en, input logic [23:0] smp, input logic [7:0] dly,
                              input logic [23:0] exp_out, input logic exp_to);
    vec_t v;
    v.en = en;
    for (int i = 0; i < NV; i++) begin
      v.smp[i] = smp;
      v.dly[i] = dly;
    end
    v.exp_out = exp_out;
    v.exp_to  = exp_to;
    return v;
  endfunction

  initial begin
    logic [SW-1:0] got;
    logic [NV-1:0] en;
    int            start;
    int            cyc;

    vecs[0] = mk(8'hFF, 24'h000100, 8'd1,  24'h000800, 1'b0);
    vecs[1] = mk(8'h03, 24'h7FFFFF, 8'd2,  24'h7FFFFF, 1'b0);
    vecs[2] = mk(8'h03, 24'h800000, 8'd0,  24'h800000, 1'b0);
    vecs[3] = mk(8'h24, 24'h000123, 8'd3,  24'h000579, 1'b0);
    vecs[3].smp[5] = 24'h000456;
    vecs[4] = mk(8'h00, 24'h00ABCD, 8'd0,  24'h000000, 1'b0);
    vecs[5] = mk(8'h07, 24'h7FFFFF, 8'd1,  24'h7FFFFE, 1'b0);
    vecs[5].smp[2] = 24'h800000;
    vecs[6] = mk(8'h01, 24'h000005, 8'd63, 24'h000005, 1'b0);
    vecs[7] = mk(8'hFF, 24'h000100, 8'd1,  24'h000700, 1'b1);
    vecs[7].dly[3] = 8'd255;
    vecs[8] = mk(8'hFF, 24'hFFFFFF, 8'd0,  24'hFFFFF8, 1'b1);

    for (int i = 0; i < NV; i++) begin
      v_smp[i] = '0;
      v_dly[i] = 0;
    end
    RESET = 1'b1;
    LRCLK = 1'b0;
    VOICE_EN = '0;
    FIFO_FULL = 1'b0;
    step(3);
    check_all_zero("reset");
    RESET = 1'b0;
    step(2);

    // Directed table.
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < NV; i++) begin
        v_smp[i] = vecs[k].smp[i];
        v_dly[i] = int'(vecs[k].dly[i]);
      end
      to_sticky = vecs[k].exp_to;
      run_frame(vecs[k].en, vecs[k].exp_out, vecs[k].exp_to, $sformatf("vec%0d", k));
    end

    // Random frames against the model.
    for (int n = 0; n < 24; n++) begin
      en = NV'($urandom);
      for (int i = 0; i < NV; i++) begin
        v_smp[i] = SW'($urandom);
        if ($urandom_range(0, 15) == 0) v_dly[i] = TO + int'($urandom_range(0, 3));
        else if ($urandom_range(0, 15) == 0) v_dly[i] = TO - 1;
        else v_dly[i] = int'($urandom_range(0, 4));
      end
      model_frame(en);
      to_sticky = to_sticky | m_to;
      run_frame(en, m_out, to_sticky, $sformatf("rand%0d", n));
    end

    // FIFO held full at WRITE, with ticks arriving during the hold.
    for (int i = 0; i < NV; i++) begin
      v_smp[i] = 24'h000001;
      v_dly[i] = 0;
    end
    req_len_q.delete();
    wr_q.delete();
    FIFO_FULL = 1'b1;
    VOICE_EN = 8'hFF;
    LRCLK = 1'b1;
    cyc = 0;
    while ((req_len_q.size() < NV) && (cyc < 500)) begin
      step(1);
      cyc++;
    end
    check("full_all_voices_done", 64'(req_len_q.size()), 64'(NV));
    step(3);
    start = wr_cnt;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) LRCLK = 1'b0;
      if (c == 6) LRCLK = 1'b1;
      step(1);
    end
    check("full_no_write", 64'(wr_cnt - start), 64'd0);
    check("full_busy", 64'(BUSY), 64'd1);
    check("full_overrun", 64'(OVERRUN), 64'd1);
    check("full_drops_1", 64'(DROP_COUNT), 64'd1);
    for (int r = 0; r < 260; r++) begin
      LRCLK = 1'b0;
      step(3);
      LRCLK = 1'b1;
      step(3);
    end
    LRCLK = 1'b0;
    step(4);
    check("full_drops_sat", 64'(DROP_COUNT), 64'd255);
    check("full_still_no_write", 64'(wr_cnt - start), 64'd0);
    FIFO_FULL = 1'b0;
    wait_write(20, got);
    check("full_release_audio", 64'(got), 64'h000008);
    step(4);
    check("full_release_writes", 64'(wr_cnt - start), 64'd1);
    check("full_release_busy", 64'(BUSY), 64'd0);

    // Asynchronous reset in the middle of the request to voice 4.
    v_dly[4] = 255;
    VOICE_EN = 8'hFF;
    LRCLK = 1'b1;
    cyc = 0;
    while (!(VOICE_REQ && (VOICE_IDX == 3'd4)) && (cyc < 200)) begin
      step(1);
      cyc++;
    end
    check("rst_reached_voice4", 64'(VOICE_REQ && (VOICE_IDX == 3'd4)), 64'd1);
    step(5);
    #2;
    RESET = 1'b1;
    #1;
    check_all_zero("async_rst");
    LRCLK = 1'b0;
    step(1);
    RESET = 1'b0;
    resp_en = 1'b0;
    start = wr_cnt;
    step(2);
    force_ack = 1'b1;
    step(1);
    force_ack = 1'b0;
    step(10);
    check("late_ack_no_write", 64'(wr_cnt - start), 64'd0);
    check("late_ack_idle", 64'(BUSY), 64'd0);
    check("late_ack_no_req", 64'(VOICE_REQ), 64'd0);
    resp_en = 1'b1;
    v_dly[4] = 0;
    to_sticky = 1'b0;
    ovr_model = 1'b0;
    drop_model = 0;
    run_frame(8'hFF, 24'h000008, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/voice_mix_scheduler.md
Name: voice_mix_scheduler

Overview:
- Sequences the shared voice-sample datapath once per audio frame and mixes the results into one sample for the audio FIFO.
- Runs in the CLK domain, between the voice generators and the audio FIFO write port; the I2S LRCLK sets the frame rate.
- Each frame it polls every enabled voice in index order over a req/ack handshake, then sums, saturates and writes exactly one 24-bit sample.
- Reports dropped frames and stalled voices.

Parameters:
- NUM_VOICES, 8, number of voice slots; power of two, 2..16.
- SAMPLE_W, 24, width of voice samples and of the FIFO word (signed two's complement).
- ACK_TIMEOUT, 64, CLK cycles allowed between VOICE_REQ and VOICE_ACK before the voice is treated as silent.

Ports:
- CLK  in  1  system clock, same domain as the FIFO write side.
- RESET  in  1  asynchronous, active-high reset.
- LRCLK  in  1  I2S frame clock, asynchronous to CLK.
- VOICE_EN  in  NUM_VOICES  per-voice enable, sampled once at frame start.
- VOICE_REQ  out  1  request for the sample of voice VOICE_IDX.
- VOICE_IDX  out  $clog2(NUM_VOICES)  voice currently addressed.
- VOICE_ACK  in  1  one-cycle pulse; VOICE_SAMPLE is valid in this cycle.
- VOICE_SAMPLE  in  SAMPLE_W  signed voice sample.
- FIFO_FULL  in  1  FIFO write-side full flag.
- FIFO_WRITE  out  1  one-cycle FIFO write strobe.
- AUDIO_OUT  out  SAMPLE_W  mixed sample; valid while FIFO_WRITE=1.
- BUSY  out  1  high in every state except IDLE.
- OVERRUN  out  1  sticky; a frame tick arrived while BUSY.
- DROP_COUNT  out  8  saturating count of dropped frame ticks.
- TIMEOUT_FLAG  out  1  sticky; at least one voice missed ACK_TIMEOUT.

Behaviour:
- Reset (asynchronous, any state) values:
  - All outputs 0, state IDLE, accumulator 0, synchroniser flops 0.
  - Any in-flight request is abandoned; a late ACK after reset is ignored.
- Frame tick:
  - LRCLK passes through a 2-flop synchroniser plus one edge flop.
  - tick = rising edge of the synchronised LRCLK. It is asserted 3 CLK cycles after the LRCLK rise, at most.
- IDLE:
  - On tick: latch VOICE_EN into en_q, clear the accumulator, set idx=0, go to SCAN.
  - Without tick: stay in IDLE.
- SCAN:
  - If en_q[idx]=1: go to REQ.
  - Else if idx=NUM_VOICES-1: go to WRITE.
  - Else: idx+1, stay in SCAN.
  - Disabled voices cost 1 cycle each and never see VOICE_REQ.
- REQ:
  - VOICE_REQ=1 and VOICE_IDX=idx; both are held stable until ACK or timeout.
  - The timer counts from 0.
  - On VOICE_ACK: add sign-extended VOICE_SAMPLE to the accumulator, drop VOICE_REQ the next cycle, go to NEXT.
  - If the timer reaches ACK_TIMEOUT-1 without ACK: add 0, set TIMEOUT_FLAG, go to NEXT.
  - ACK and timeout in the same cycle: the ACK wins.
- NEXT:
  - If idx=NUM_VOICES-1: go to WRITE.
  - Else: idx+1, go to SCAN.
- WRITE:
  - If FIFO_FULL=0: FIFO_WRITE=1 for one cycle, with AUDIO_OUT = the saturated accumulator; go to IDLE.
  - If FIFO_FULL=1: hold in WRITE, FIFO_WRITE=0, AUDIO_OUT held.
- Arithmetic:
  - Accumulator width is SAMPLE_W+$clog2(NUM_VOICES), signed.
  - Output saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - No wrap-around is permitted.
  - All voices disabled produces an output sample of 0.
- Tick while BUSY:
  - The tick is dropped and the frame in progress continues unaffected.
  - OVERRUN is set; DROP_COUNT increments and saturates at 255.
  - A tick in the same cycle the FSM returns to IDLE counts as BUSY, so it is dropped.
- Latency: with every voice acking immediately, the FIFO is not full at WRITE.
- VOICE_ACK outside REQ is ignored.
- Sticky flags clear only on RESET.

Decomposition:
- Shared package holds:
  - enum mix_state_t {IDLE, SCAN, REQ, NEXT, WRITE}.
  - Function sat_to_sample(), which saturates a wide signed value to SAMPLE_W.
  - Default constants NUM_VOICES_DEF=8 and SAMPLE_W_DEF=24.
- One sub-module, lrclk_tick_sync: the 2-flop synchroniser plus rising-edge detector, output tick.
- FSM, accumulator and counters stay in the top.

Test Plan:
1. NUM_VOICES=8, VOICE_EN=8'hFF, every voice acks 1 cycle after REQ with sample 24'h000100, one LRCLK rise -> exactly one FIFO_WRITE with AUDIO_OUT=24'h000800; VOICE_IDX visits 0..7 in order.
2. Voices 0 and 1 each return 24'h7FFFFF, all other voices disabled -> AUDIO_OUT=24'h7FFFFF (saturated). Repeat with 24'h800000 -> 24'h800000.
3. VOICE_EN=8'b00100100 -> VOICE_REQ asserted only for idx 2 and 5; VOICE_EN=0 -> one write of 24'h000000.
4. Voice 3 never acks -> VOICE_REQ for idx 3 held exactly 64 cycles, TIMEOUT_FLAG=1, and the sum excludes voice 3; the frame still completes.
5. FIFO_FULL=1 held 20 cycles at WRITE, with a second LRCLK rise during the hold -> no FIFO_WRITE while full; one write once FIFO_FULL falls; OVERRUN=1, DROP_COUNT=1.
6. RESET pulsed while in REQ for voice 4 -> all outputs 0 and state IDLE immediately (asynchronously); an ACK pulse 2 cycles later causes no write; the next tick runs a clean frame.
